// File: rtl/ipu_pkg.sv
// Shared types, opcodes and coprocessor instruction packing for the IPU frame sequencer.
package ipu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ROW_GAP = 3'd4
    } ipu_state_e;

    localparam logic [3:0] OP_CONV       = 4'b0101;
    localparam logic [3:0] OP_CONV_TRSP  = 4'b0110;
    localparam logic [3:0] OP_CONV_ROB   = 4'b0111;
    localparam logic [3:0] OP_B2G        = 4'b1000;
    localparam logic [3:0] OP_PHOTO_CONV = 4'b1110;
    localparam logic [3:0] OP_READ_IMAGE = 4'b1111;

    localparam int INST_CW = 9;

    // Coprocessor instruction layout: {10'b0, v, h, opcode}
    function automatic logic [31:0] pack_cp_inst(input logic [INST_CW-1:0] v,
                                                 input logic [INST_CW-1:0] h,
                                                 input logic [3:0]         op);
        return {10'b0, v, h, op};
    endfunction

endpackage

// File: rtl/ipu_result_fifo.sv
// Small synchronous FIFO buffering coprocessor result bytes ahead of the frame writer.
module ipu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             wr_en_s, rd_en_s;

    // Next-state pointers and occupancy; simultaneous push/pop keeps the count
    always_comb begin
        rd_en_s  = pop && (count_q != {CNTW{1'b0}});
        wr_en_s  = push && ((count_q != CNTW'(DEPTH)) || rd_en_s);
        wr_ptr_d = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CNTW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= din;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ipu_frame_sequencer.sv
// Walks a frame: preloads K line-buffer rows, issues one convolution per pixel and
// buffers the selected result byte for the frame writer.
module ipu_frame_sequencer #(
    parameter int IMG_W        = 512,
    parameter int IMG_H        = 480,
    parameter int PIX_PER_WORD = 4,
    parameter int MAX_K        = 5,
    parameter int RES_DEPTH    = 4,
    parameter int CW           = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    k_size,
    input  logic [3:0]    opcode,
    input  logic          byte_sel,
    input  logic          abort,
    output logic [15:0]   mem_addr,
    output logic          lb_load,
    output logic [CW-1:0] lb_col,
    output logic          lb_shift,
    output logic          cp_req,
    output logic [31:0]   cp_inst,
    input  logic          cp_busy,
    input  logic          cp_done,
    input  logic [31:0]   cp_result,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          done
);
    import ipu_pkg::*;

    localparam int WPR  = IMG_W / PIX_PER_WORD;
    localparam int WW   = 16 - CW;
    localparam int LLW  = $clog2(MAX_K + 1);
    localparam int CNTW = $clog2(RES_DEPTH) + 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW  = CW'(IMG_H - 1);

    ipu_state_e      state_q, state_d;
    logic            start_q;
    logic [2:0]      k_q, k_d;
    logic [3:0]      op_q, op_d;
    logic            byte_sel_q, byte_sel_d;
    logic [LLW-1:0]  lines_left_q, lines_left_d;
    logic [CW-1:0]   load_row_q, load_row_d;
    logic [WW-1:0]   word_q, word_d;
    logic [CW-1:0]   v_q, v_d;
    logic [CW-1:0]   h_q, h_d;
    logic            lb_load_q, lb_load_d;
    logic [CW-1:0]   lb_col_q, lb_col_d;
    logic            lb_shift_q, lb_shift_d;
    logic            cp_req_q, cp_req_d;
    logic [31:0]     cp_inst_q, cp_inst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            start_edge_s;
    logic [2:0]      k_eff_s;
    logic [CW:0]     gap_row_s;
    logic            push_s, pop_s, has_space_s;
    logic [7:0]      push_data_s;
    logic [CNTW-1:0] fifo_count_s;
    logic            unused_s;

    assign start_edge_s = start && !start_q;
    assign k_eff_s      = ((k_size == 3'd0) || (32'(k_size) > MAX_K)) ? 3'(MAX_K) : k_size;
    assign push_data_s  = byte_sel_q ? cp_result[23:16] : cp_result[7:0];
    assign pop_s        = res_valid && res_ready;
    // Outstanding requests count against space so a result can always be accepted
    assign has_space_s  = (32'(fifo_count_s) + 32'(cp_req_q)) < 32'(RES_DEPTH);
    assign unused_s     = ^{cp_result[31:24], cp_result[15:8]};

    // Sequencer next-state: abort overrides every state
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        op_d         = op_q;
        byte_sel_d   = byte_sel_q;
        lines_left_d = lines_left_q;
        load_row_d   = load_row_q;
        word_d       = word_q;
        v_d          = v_q;
        h_d          = h_q;
        lb_load_d    = lb_load_q;
        lb_shift_d   = 1'b0;
        cp_req_d     = cp_req_q;
        cp_inst_d    = cp_inst_q;
        done_d       = 1'b0;
        push_s       = 1'b0;
        gap_row_s    = {1'b0, v_q} + (CW+1)'(k_q) - (CW+1)'(1);
        if (abort) begin
            state_d   = ST_IDLE;
            cp_req_d  = 1'b0;
            lb_load_d = 1'b0;
            done_d    = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    v_d        = {CW{1'b0}};
                    h_d        = {CW{1'b0}};
                    word_d     = {WW{1'b0}};
                    load_row_d = {CW{1'b0}};
                    cp_req_d   = 1'b0;
                    if (start_edge_s) begin
                        k_d          = k_eff_s;
                        op_d         = opcode;
                        byte_sel_d   = byte_sel;
                        lines_left_d = LLW'(k_eff_s);
                        lb_load_d    = 1'b1;
                        state_d      = ST_PRELOAD;
                    end else begin
                        lines_left_d = {LLW{1'b0}};
                        lb_load_d    = 1'b0;
                    end
                end
                ST_PRELOAD: begin
                    if (word_q == LAST_WORD) begin
                        word_d       = {WW{1'b0}};
                        lines_left_d = lines_left_q - LLW'(1);
                        if (lines_left_q == LLW'(1)) begin
                            lb_load_d = 1'b0;
                            state_d   = ST_ISSUE;
                        end else begin
                            load_row_d = (load_row_q < LAST_ROW) ? load_row_q + CW'(1) : LAST_ROW;
                        end
                    end else begin
                        word_d = word_q + WW'(1);
                    end
                end
                ST_ISSUE: begin
                    if (!cp_busy && has_space_s) begin
                        cp_req_d  = 1'b1;
                        cp_inst_d = pack_cp_inst(INST_CW'(v_q), INST_CW'(h_q), op_q);
                        state_d   = ST_WAIT;
                    end else begin
                        cp_req_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cp_done) begin
                        push_s     = 1'b1;
                        cp_req_d   = 1'b0;
                        lb_shift_d = 1'b1;
                        if (h_q < LAST_COL) begin
                            h_d     = h_q + CW'(1);
                            state_d = ST_ISSUE;
                        end else if (v_q < LAST_ROW) begin
                            h_d     = {CW{1'b0}};
                            v_d     = v_q + CW'(1);
                            state_d = ST_ROW_GAP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cp_req_d = 1'b1;
                    end
                end
                ST_ROW_GAP: begin
                    // v already points at the new row; fetch its bottom kernel line, clamped
                    lines_left_d = LLW'(1);
                    word_d       = {WW{1'b0}};
                    lb_load_d    = 1'b1;
                    load_row_d   = (gap_row_s > {1'b0, LAST_ROW}) ? LAST_ROW : gap_row_s[CW-1:0];
                    state_d      = ST_PRELOAD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        lb_col_d = CW'(32'(word_d) * PIX_PER_WORD);
        busy_d   = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            k_q          <= 3'd0;
            op_q         <= 4'd0;
            byte_sel_q   <= 1'b0;
            lines_left_q <= {LLW{1'b0}};
            load_row_q   <= {CW{1'b0}};
            word_q       <= {WW{1'b0}};
            v_q          <= {CW{1'b0}};
            h_q          <= {CW{1'b0}};
            lb_load_q    <= 1'b0;
            lb_col_q     <= {CW{1'b0}};
            lb_shift_q   <= 1'b0;
            cp_req_q     <= 1'b0;
            cp_inst_q    <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            k_q          <= k_d;
            op_q         <= op_d;
            byte_sel_q   <= byte_sel_d;
            lines_left_q <= lines_left_d;
            load_row_q   <= load_row_d;
            word_q       <= word_d;
            v_q          <= v_d;
            h_q          <= h_d;
            lb_load_q    <= lb_load_d;
            lb_col_q     <= lb_col_d;
            lb_shift_q   <= lb_shift_d;
            cp_req_q     <= cp_req_d;
            cp_inst_q    <= cp_inst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    ipu_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (8)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (res_data),
        .count (fifo_count_s)
    );

    assign mem_addr  = {load_row_q, word_q};
    assign lb_load   = lb_load_q;
    assign lb_col    = lb_col_q;
    assign lb_shift  = lb_shift_q;
    assign cp_req    = cp_req_q;
    assign cp_inst   = cp_inst_q;
    assign res_valid = (fifo_count_s != {CNTW{1'b0}});
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Directed bench for the frame sequencer on an 8x4 frame with a 2-entry result FIFO.
module tb_ipu_frame_sequencer;
    import ipu_pkg::*;

    localparam int W = 8, H = 4, PPW = 4, MK = 5, RD = 2, CWT = 9;

    logic        clk, rst_n, start, byte_sel, abort;
    logic [2:0]  k_size;
    logic [3:0]  opcode;
    logic [15:0] mem_addr;
    logic        lb_load, lb_shift, cp_req, cp_busy, cp_done;
    logic [CWT-1:0] lb_col;
    logic [31:0] cp_inst, cp_result;
    logic        res_valid, res_ready, busy, done;
    logic [7:0]  res_data;

    int n_total = 0, n_bad = 0;
    int req_cnt = 0, done_cnt = 0, shift_cnt = 0, load_cycles = 0, inst_unstable = 0;
    int cp_wait = 0, lat;
    logic [8:0]  last_load_row = 9'd0;
    logic [31:0] req_inst = 32'd0;
    bit cp_req_prev = 1'b0, cp_pending = 1'b0, cp_auto = 1'b1, hold_en = 1'b0, force_res = 1'b0;
    logic [7:0] res_q[$];

    ipu_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .PIX_PER_WORD(PPW), .MAX_K(MK), .RES_DEPTH(RD), .CW(CWT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_size(k_size), .opcode(opcode),
        .byte_sel(byte_sel), .abort(abort), .mem_addr(mem_addr), .lb_load(lb_load),
        .lb_col(lb_col), .lb_shift(lb_shift), .cp_req(cp_req), .cp_inst(cp_inst),
        .cp_busy(cp_busy), .cp_done(cp_done), .cp_result(cp_result),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Coprocessor reply: low byte = v*8+h, byte 2 = that value xor A5
    function automatic logic [31:0] res_word(input logic [31:0] inst);
        logic [7:0] lo;
        lo = 8'((32'(inst[21:13]) << 3) + 32'(inst[12:4]));
        return {8'h00, lo ^ 8'hA5, 8'h00, lo};
    endfunction

    task automatic step();
        if (res_valid && res_ready) res_q.push_back(res_data);
        @(negedge clk);
        cp_done = 1'b0;
        if (done) done_cnt++;
        if (lb_shift) shift_cnt++;
        if (lb_load) begin
            load_cycles++;
            last_load_row = mem_addr[15:7];
        end
        if (cp_req && cp_req_prev && (cp_inst != req_inst)) inst_unstable++;
        if (cp_req && !cp_req_prev) begin
            req_cnt++;
            req_inst = cp_inst;
            if (cp_auto && !(hold_en && cp_inst[21:13] == 9'd1 && cp_inst[12:4] == 9'd5)) begin
                cp_pending = 1'b1;
                cp_wait = 0;
            end
        end
        cp_req_prev = cp_req;
        if (cp_pending) begin
            cp_wait++;
            if (cp_wait == 2) begin
                cp_done = 1'b1;
                cp_result = force_res ? 32'h00AB00CD : res_word(req_inst);
                cp_pending = 1'b0;
            end
        end
    endtask

    task automatic run_to_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        repeat (6) step();
    endtask

    task automatic new_start();
        start = 1'b0;
        step();
        res_q.delete();
        req_cnt = 0; done_cnt = 0; shift_cnt = 0; load_cycles = 0; inst_unstable = 0;
        start = 1'b1;
    endtask

    task automatic wait_first_req(input string tag);
        lat = 0;
        while (req_cnt == 0 && lat < 200) begin
            step();
            lat++;
        end
        if (req_cnt == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] got;
        chk({tag, "_count"}, 32'(res_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            got = (i < res_q.size()) ? res_q[i] : 8'hxx;
            chk(tag, {24'd0, got}, 32'(i));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_size = 3'd3; opcode = OP_CONV; byte_sel = 1'b0;
        abort = 1'b0; cp_busy = 1'b0; cp_done = 1'b0; cp_result = 32'd0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {26'd0, busy, done, cp_req, lb_load, lb_shift, res_valid}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_inst", cp_inst, 32'd0);
        chk("rst_data", {24'd0, res_data}, 32'd0);
        rst_n = 1'b1;
        step();

        // Full 8x4 frame, K=3
        new_start();
        wait_first_req("k3");
        chk("k3_first_req_lat", 32'(lat - 1), 32'd7);
        chk("k3_preload_cycles", 32'(load_cycles), 32'd6);
        chk("k3_first_inst", req_inst, 32'h0000_0005);
        run_to_done(1000);
        check_frame("frame_px");
        chk("frame_reqs", 32'(req_cnt), 32'd32);
        chk("frame_done", 32'(done_cnt), 32'd1);
        chk("frame_shifts", 32'(shift_cnt), 32'd32);
        chk("frame_last_inst", req_inst, 32'h0000_6075);
        chk("frame_load_cycles", 32'(load_cycles), 32'd12);
        chk("bottom_clamp_row", {23'd0, last_load_row}, 32'd3);
        chk("inst_stable", 32'(inst_unstable), 32'd0);

        // Backpressure with a 2-entry FIFO
        res_ready = 1'b0;
        new_start();
        repeat (60) step();
        chk("bp_reqs", 32'(req_cnt), 32'd2);
        chk("bp_req_low", {31'd0, cp_req}, 32'd0);
        chk("bp_valid", {31'd0, res_valid}, 32'd1);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        res_ready = 1'b1;
        run_to_done(1500);
        check_frame("bp_px");
        chk("bp_done", 32'(done_cnt), 32'd1);

        // Abort while waiting on pixel (1,5)
        hold_en = 1'b1;
        new_start();
        for (int i = 0; i < 500 && req_cnt < 14; i++) step();
        chk("abort_target", req_inst, 32'h0000_2055);
        chk("abort_wait_req", {31'd0, cp_req}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_req", {31'd0, cp_req}, 32'd0);
        chk("abort_load", {31'd0, lb_load}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd1);
        cp_done = 1'b1;
        cp_result = 32'h0000_0077;
        step();
        repeat (5) step();
        chk("abort_results", 32'(res_q.size()), 32'd13);
        chk("abort_done_once", 32'(done_cnt), 32'd1);
        hold_en = 1'b0;
        new_start();
        wait_first_req("restart");
        chk("restart_inst", req_inst, 32'h0000_0005);
        run_to_done(1000);
        chk("restart_results", 32'(res_q.size()), 32'd32);

        // Kernel height clamp and minimum
        k_size = 3'd7;
        new_start();
        wait_first_req("k7");
        chk("k7_first_req_lat", 32'(lat - 1), 32'd11);
        chk("k7_load_cycles", 32'(load_cycles), 32'd10);
        chk("k7_last_row", {23'd0, last_load_row}, 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        k_size = 3'd1;
        new_start();
        wait_first_req("k1");
        chk("k1_first_req_lat", 32'(lat - 1), 32'd3);
        chk("k1_load_cycles", 32'(load_cycles), 32'd2);
        chk("k1_last_row", {23'd0, last_load_row}, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();

        // Upper result byte selection
        force_res = 1'b1;
        byte_sel = 1'b1;
        new_start();
        for (int i = 0; i < 200 && res_q.size() == 0; i++) step();
        chk("byte_sel_hi", (res_q.size() > 0) ? {24'd0, res_q[0]} : 32'hxxxx_xxxx, 32'h0000_00AB);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ipu_frame_sequencer.md
# ipu_frame_sequencer

Parametrised successor of the image-processing-unit (IPU) frame sequencer. It walks a stored frame pixel by pixel. It preloads the line buffers with K source rows, then issues one convolution instruction per output pixel to the convolution coprocessor. It collects each result into a small output FIFO that drains to the VGA/frame-memory writer with backpressure. The block sits between the HPS instruction decoder, the frame memory read port, the line buffers and the coprocessor. It adds programmable kernel height, frame geometry, abort and result buffering.

## Interface
- IMG_W, 512: frame width in pixels. Must be a multiple of PIX_PER_WORD.
- IMG_H, 480: frame height in rows.
- PIX_PER_WORD, 4: pixels per 32-bit memory word.
- MAX_K, 5: largest kernel height supported.
- RES_DEPTH, 4: result FIFO depth. Must be a power of two, at least 2.
- CW, 9: coordinate width. Must satisfy 2^CW ≥ max(IMG_W, IMG_H).
- clk  in  1  system clock. One clock domain; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sensitive. Rising edge detected internally; ignored while busy.
- k_size  in  3  kernel height K, legal 1..MAX_K. Sampled on start; illegal values clamp to MAX_K.
- opcode  in  4  coprocessor opcode. Sampled on start.
- byte_sel  in  1  selects result byte: 0 → cp_result[7:0], 1 → cp_result[23:16]. Sampled on start.
- abort  in  1  synchronous abort.
- mem_addr  out  16  frame read address {row[CW-1:0], word index}.
- lb_load  out  1  high while a line is streaming into the line buffers.
- lb_col  out  CW  pixel column of the current load word: word index × PIX_PER_WORD.
- lb_shift  out  1  one-cycle pulse that advances the line-buffer window.
- cp_req  out  1  coprocessor request. Held until cp_done.
- cp_inst  out  32  {10'b0, v[CW-1:0], h[CW-1:0], opcode}, laid out for CW=9.
- cp_busy  in  1  coprocessor wait signal.
- cp_done  in  1  single-cycle result strobe.
- cp_result  in  32  coprocessor result word.
- res_valid  out  1  FIFO not empty.
- res_data  out  8  FIFO head.
- res_ready  in  1  consumer accept.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on frame completion or abort.

All outputs reset to 0.

## Operation
- States: IDLE, PRELOAD, ISSUE, WAIT, ROW_GAP.
- **IDLE**: counters cleared. A start rising edge latches k_size, opcode and byte_sel, sets lines_left=K and goes to PRELOAD.
- **PRELOAD**: lb_load=1 and mem_addr steps one word per cycle.
  - At the last word of a row (IMG_W/PIX_PER_WORD−1), the row increments and lines_left decrements.
  - When lines_left reaches 0, go to ISSUE.
  - The load row is clamped to IMG_H−1, so bottom rows are replicated.
- **ISSUE**: when cp_busy=0 and the FIFO has space, assert cp_req with the current (v,h), then go to WAIT.
  - FIFO space means occupancy plus outstanding requests is less than RES_DEPTH.
- **WAIT**: on cp_done, push the selected byte, drop cp_req, pulse lb_shift, then advance.
  - If h < IMG_W−1: h+1, back to ISSUE.
  - Else if v < IMG_H−1: h=0, v+1, go to ROW_GAP.
  - Else: pulse done, go to IDLE.
- **ROW_GAP**: one-cycle delay, then PRELOAD with lines_left=1, loading row min(v+K−1, IMG_H−1).
- **abort**: from any state, next cycle is IDLE with cp_req=0 and lb_load=0. done pulses once. FIFO contents are kept and continue to drain.
  - A cp_done that arrives after an abort is discarded.
- **FIFO**: push and pop in the same cycle leaves occupancy unchanged. A push into a full FIFO cannot occur because of the ISSUE gating.

## Timing
- Preload latency: K × IMG_W/PIX_PER_WORD cycles from the start edge to the first cp_req. This is +1 cycle for start-edge registration.
- cp_req rises 1 cycle after ISSUE is entered and the issue conditions are met.
- A pushed result is visible on res_valid/res_data the next cycle.
- lb_shift coincides with the cycle after cp_done.
- cp_inst is stable for the whole time cp_req is high.
- done is exactly one cycle wide and never asserts outside a frame or abort.

## Structure
- Package ipu_pkg holds:
  - the state enum;
  - opcode constants (CONV=4'b0101, CONV_TRSP=4'b0110, CONV_ROB=4'b0111, B2G=4'b1000, PHOTO_CONV=4'b1110, READ_IMAGE=4'b1111);
  - the cp_inst packing function.
- Sub-module ipu_result_fifo: parametrised synchronous FIFO with count output. The sequencer holds the FSM, coordinate counters and line loader.

## Test plan
- **Small frame (IMG_W=8, IMG_H=4, PIX_PER_WORD=4, K=3):** start, cp_done 2 cycles after each cp_req, res_ready=1.
  - First cp_req after 3×2+1 = 7 cycles.
  - 32 results, done once.
  - Last cp_inst has v=3, h=7.
- **Backpressure (RES_DEPTH=2, res_ready=0):**
  - Exactly 2 requests are issued, then cp_req stays low.
  - Raising res_ready resumes issue with no lost or duplicated data.
- **Abort mid-WAIT at pixel (1,5):**
  - Next cycle: IDLE, cp_req=0, done=1.
  - A late cp_done produces no push.
  - A new start restarts from (0,0).
- **k_size=7 with MAX_K=5:** the preload loads 5 rows. **k_size=1:** the preload loads 1 row.
- **Bottom clamp (IMG_H=4, K=3):** the ROW_GAP load for v=3 has mem_addr row = 3, not 5.
- **byte_sel=1 with cp_result=32'h00AB00CD:** res_data=8'hAB.
